// File: rtl/uart_rx_fifo_writer_if.sv
// ============================================================================
// Module  : uart_rx_fifo_writer_if
// Brief   : Byte-FIFO write port (strobe, data, full) shared by writer and FIFO.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_rx_fifo_writer_if;
    logic       wr;
    logic [7:0] din;
    logic       full;

    modport master (output wr, output din, input full);
    modport slave  (input wr, input din, output full);
endinterface

`default_nettype wire

// File: rtl/uart_rx_fifo_writer.sv
// ============================================================================
// Module  : uart_rx_fifo_writer
// Brief   : 8N1 UART receiver pushing good bytes into a byte FIFO; reports
//           framing errors and counts bytes dropped on a full FIFO.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_fifo_writer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              rx,
    uart_rx_fifo_writer_if.master  fifo,
    output logic                   frame_err,
    output logic                   overrun,
    output logic [7:0]             drop_cnt,
    output logic                   busy
);

    localparam logic [15:0] C_BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] C_HALF_LAST = 16'((CLKS_PER_BIT / 2) - 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_DATA      = 3'd2;
    localparam logic [2:0] S_STOP      = 3'd3;
    localparam logic [2:0] S_PUSH      = 3'd4;
    localparam logic [2:0] S_WAIT_IDLE = 3'd5;

    logic [2:0]  r_state;
    logic [2:0]  w_next;
    logic        r_rx_meta;
    logic        r_rx_s;
    logic [15:0] r_timer;
    logic [2:0]  r_bit_idx;
    logic [7:0]  r_byte;
    logic [7:0]  r_din;
    logic        w_tick_half;
    logic        w_tick_bit;

    assign w_tick_half = (r_timer == C_HALF_LAST);
    assign w_tick_bit  = (r_timer == C_BIT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (!r_rx_s) w_next = S_START;
            end
            S_START: begin
                if (w_tick_half) w_next = r_rx_s ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (w_tick_bit && (r_bit_idx == 3'd7)) w_next = S_STOP;
            end
            S_STOP: begin
                if (w_tick_bit) begin
                    if (!r_rx_s)        w_next = S_WAIT_IDLE;
                    else if (fifo.full) w_next = S_IDLE;
                    else                w_next = S_PUSH;
                end
            end
            S_PUSH:      w_next = S_IDLE;
            S_WAIT_IDLE: begin
                if (r_rx_s) w_next = S_IDLE;
            end
            default:     w_next = S_IDLE;
        endcase
    end

    always_comb begin
        fifo.wr = (r_state == S_PUSH);
        busy    = (r_state != S_IDLE);
    end

    // Timer restarts on every state change and on each data-bit sample point
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
            r_timer   <= 16'd0;
            r_bit_idx <= 3'd0;
            r_byte    <= 8'd0;
            r_din     <= 8'd0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            drop_cnt  <= 8'd0;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
            frame_err <= 1'b0;
            overrun   <= 1'b0;

            if ((r_state != w_next) || ((r_state == S_DATA) && w_tick_bit)) begin
                r_timer <= 16'd0;
            end else begin
                r_timer <= r_timer + 16'd1;
            end

            if (r_state == S_START) begin
                r_bit_idx <= 3'd0;
            end else if ((r_state == S_DATA) && w_tick_bit) begin
                r_byte[r_bit_idx] <= r_rx_s;
                r_bit_idx         <= r_bit_idx + 3'd1;
            end

            if ((r_state == S_STOP) && w_tick_bit) begin
                if (!r_rx_s) begin
                    frame_err <= 1'b1;
                end else if (fifo.full) begin
                    overrun <= 1'b1;
                    if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
                end else begin
                    r_din <= r_byte;
                end
            end
        end
    end

    assign fifo.din = r_din;

endmodule

`default_nettype wire
